// File: rtl/montgomery_pkg.sv
// Shared constants and types for the Montgomery constant streamer.
// Block geometry, channel FSM states and load channel selects.
package montgomery_pkg;

  localparam int REGISTER_SIZE = 32;
  localparam int BITS_IN_NUM   = 2048;
  localparam int NUM_BLOCKS    = BITS_IN_NUM / REGISTER_SIZE;

  typedef enum logic [1:0] {
    EMPTY,
    LOADING,
    LOADED
  } const_chan_state_t;

  localparam logic SEL_N = 1'b0;
  localparam logic SEL_K = 1'b1;

endpackage

// File: rtl/const_block_channel.sv
// One constant channel: block store, write/read pointers, load FSM.
// Ports: clk_in, rst_n_in (async low), load_valid_in, load_block_in,
//   rewind_in, consumed_in -> block_out, loaded_out, underrun_err_out.
module const_block_channel #(
  parameter int BLOCK_W = 32,
  parameter int DEPTH   = 64
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               load_valid_in,
  input  logic [BLOCK_W-1:0] load_block_in,
  input  logic               rewind_in,
  input  logic               consumed_in,
  output logic [BLOCK_W-1:0] block_out,
  output logic               loaded_out,
  output logic               underrun_err_out
);
  import montgomery_pkg::*;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [BLOCK_W-1:0] mem [DEPTH];

  const_chan_state_t state;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_idx;
  logic              is_loaded;

  assign is_loaded = (state == LOADED);

  // A load from EMPTY or LOADED restarts the constant at block 0.
  assign wr_idx = (state == LOADING) ? wr_ptr : '0;

  // Storage is deliberately not reset.
  always_ff @(posedge clk_in) begin
    if (load_valid_in) begin
      mem[wr_idx] <= load_block_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state            <= EMPTY;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      loaded_out       <= 1'b0;
      underrun_err_out <= 1'b0;
    end else begin
      if (consumed_in && !is_loaded) begin
        underrun_err_out <= 1'b1;
      end
      if (load_valid_in) begin
        rd_ptr <= '0;
        if (wr_idx == LAST) begin
          state      <= LOADED;
          wr_ptr     <= '0;
          loaded_out <= 1'b1;
        end else begin
          state      <= LOADING;
          wr_ptr     <= wr_idx + 1'b1;
          loaded_out <= 1'b0;
        end
      end else if (rewind_in) begin
        rd_ptr <= '0;
      end else if (consumed_in && is_loaded) begin
        // Explicit wrap keeps non-power-of-two depths correct.
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
    end
  end

  assign block_out = loaded_out ? mem[rd_ptr] : '0;

endmodule

// File: rtl/montgomery_constant_streamer.sv
// Streams the N and k Montgomery constants block-wise, replaying forever.
// Ports: clk_in, rst_n_in, load_* (host side), rewind_in, consumed_N/k_in
//   -> N_out, k_out, N/k_loaded_out, ready_out, underrun_err_out.
module montgomery_constant_streamer #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 2048
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     load_valid_in,
  input  logic                     load_sel_in,
  input  logic [REGISTER_SIZE-1:0] load_block_in,
  input  logic                     rewind_in,
  input  logic                     consumed_N_in,
  input  logic                     consumed_k_in,
  output logic [REGISTER_SIZE-1:0] N_out,
  output logic [REGISTER_SIZE-1:0] k_out,
  output logic                     N_loaded_out,
  output logic                     k_loaded_out,
  output logic                     ready_out,
  output logic                     underrun_err_out
);
  import montgomery_pkg::*;

  localparam int NUM_BLOCKS = BITS_IN_NUM / REGISTER_SIZE;

  logic load_n;
  logic load_k;
  logic err_n;
  logic err_k;

  assign load_n = load_valid_in && (load_sel_in == SEL_N);
  assign load_k = load_valid_in && (load_sel_in == SEL_K);

  const_block_channel #(
    .BLOCK_W (REGISTER_SIZE),
    .DEPTH   (NUM_BLOCKS)
  ) u_chan_n (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .load_valid_in    (load_n),
    .load_block_in    (load_block_in),
    .rewind_in        (rewind_in),
    .consumed_in      (consumed_N_in),
    .block_out        (N_out),
    .loaded_out       (N_loaded_out),
    .underrun_err_out (err_n)
  );

  const_block_channel #(
    .BLOCK_W (REGISTER_SIZE),
    .DEPTH   (NUM_BLOCKS)
  ) u_chan_k (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .load_valid_in    (load_k),
    .load_block_in    (load_block_in),
    .rewind_in        (rewind_in),
    .consumed_in      (consumed_k_in),
    .block_out        (k_out),
    .loaded_out       (k_loaded_out),
    .underrun_err_out (err_k)
  );

  assign ready_out        = N_loaded_out & k_loaded_out;
  assign underrun_err_out = err_n | err_k;

endmodule

// File: tb/tb_montgomery_constant_streamer.sv
// Self-checking bench for montgomery_constant_streamer.
// Table vectors plus scoreboard-checked consume streams.
module tb_montgomery_constant_streamer;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        load_valid_in;
  logic        load_sel_in;
  logic [31:0] load_block_in;
  logic        rewind_in;
  logic        consumed_N_in;
  logic        consumed_k_in;
  logic [31:0] N_out;
  logic [31:0] k_out;
  logic        N_loaded_out;
  logic        k_loaded_out;
  logic        ready_out;
  logic        underrun_err_out;

  montgomery_constant_streamer dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .load_valid_in    (load_valid_in),
    .load_sel_in      (load_sel_in),
    .load_block_in    (load_block_in),
    .rewind_in        (rewind_in),
    .consumed_N_in    (consumed_N_in),
    .consumed_k_in    (consumed_k_in),
    .N_out            (N_out),
    .k_out            (k_out),
    .N_loaded_out     (N_loaded_out),
    .k_loaded_out     (k_loaded_out),
    .ready_out        (ready_out),
    .underrun_err_out (underrun_err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        cn;
    logic        ck;
    logic        rew;
    logic [31:0] en;
    logic [31:0] ek;
  } vec_t;

  vec_t        tbl[6];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    load_valid_in = 1'b0;
    load_sel_in   = 1'b0;
    load_block_in = '0;
    rewind_in     = 1'b0;
    consumed_N_in = 1'b0;
    consumed_k_in = 1'b0;
  endtask

  // Drive one cycle of inputs from a negedge, return at the next negedge.
  task automatic cyc(input logic lv, input logic sel,
                     input logic [31:0] blk, input logic rew,
                     input logic cn, input logic ck);
    load_valid_in = lv;
    load_sel_in   = sel;
    load_block_in = blk;
    rewind_in     = rew;
    consumed_N_in = cn;
    consumed_k_in = ck;
    @(negedge clk_in);
    idle_in();
  endtask

  task automatic load_chan(input logic sel, input logic [31:0] base,
                           input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      cyc(1'b1, sel, base + 32'(i), 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic consume_n(input int n, input logic cn, input logic ck);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b0, cn, ck);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h1001, 32'h2000};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h1001, 32'h2001};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h1002, 32'h2002};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 32'h1000, 32'h2000};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h1000, 32'h2000};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h1000, 32'h2001};

    idle_in();
    rst_n_in = 1'b1;
    #1 rst_n_in = 1'b0;
    #1;
    chk("rst_n_loaded", N_loaded_out, 1'b0);
    chk("rst_k_loaded", k_loaded_out, 1'b0);
    chk("rst_ready", ready_out, 1'b0);
    chk("rst_err", underrun_err_out, 1'b0);
    chk("rst_n_out", N_out, 32'h0);
    chk("rst_k_out", k_out, 32'h0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Underrun on an empty channel is sticky.
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("underrun_set", underrun_err_out, 1'b1);
    chk("underrun_k_out", k_out, 32'h0);
    consume_n(3, 1'b0, 1'b0);
    chk("underrun_sticky", underrun_err_out, 1'b1);
    rst_n_in = 1'b0;
    #1;
    chk("underrun_rst_clr", underrun_err_out, 1'b0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Full loads.
    load_chan(1'b0, 32'h1000, 0, 63);
    chk("n_not_loaded_63", N_loaded_out, 1'b0);
    chk("n_out_while_loading", N_out, 32'h0);
    load_chan(1'b0, 32'h1000, 63, 1);
    chk("n_loaded", N_loaded_out, 1'b1);
    chk("ready_n_only", ready_out, 1'b0);
    load_chan(1'b1, 32'h2000, 0, 64);
    chk("k_loaded", k_loaded_out, 1'b1);
    chk("ready", ready_out, 1'b1);
    chk("n_block0", N_out, 32'h1000);
    chk("k_block0", k_out, 32'h2000);

    // 64 N consumes, wrapping back to block 0.
    for (int i = 0; i < 64; i++) begin
      sb_q.push_back(32'h1000 + 32'((i + 1) % 64));
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      chk("n_sweep", N_out, sb_q.pop_front());
    end
    chk("k_steady", k_out, 32'h2000);

    for (int i = 0; i < 6; i++) begin
      sb_q.push_back(tbl[i].en);
      sb_q.push_back(tbl[i].ek);
      cyc(1'b0, 1'b0, '0, tbl[i].rew, tbl[i].cn, tbl[i].ck);
      chk("tbl_n", N_out, sb_q.pop_front());
      chk("tbl_k", k_out, sb_q.pop_front());
    end
    chk("tbl_no_err", underrun_err_out, 1'b0);

    // Rewind beats a simultaneous consume.
    consume_n(5, 1'b1, 1'b0);
    chk("n_ptr5", N_out, 32'h1005);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("rewind_n", N_out, 32'h1000);
    chk("rewind_k", k_out, 32'h2000);

    // Reload N mid-stream, with a consume colliding with the first block.
    consume_n(10, 1'b1, 1'b0);
    chk("n_ptr10", N_out, 32'h100A);
    consume_n(3, 1'b0, 1'b1);
    chk("k_ptr3", k_out, 32'h2003);
    cyc(1'b1, 1'b0, 32'hA000, 1'b0, 1'b1, 1'b0);
    chk("reload_n_drop", N_loaded_out, 1'b0);
    chk("reload_ready_drop", ready_out, 1'b0);
    chk("reload_n_out0", N_out, 32'h0);
    chk("reload_no_err", underrun_err_out, 1'b0);
    chk("reload_k_kept", k_out, 32'h2003);
    load_chan(1'b0, 32'hA000, 1, 63);
    chk("reload_n_loaded", N_loaded_out, 1'b1);
    chk("reload_n_out", N_out, 32'hA000);
    chk("reload_ready", ready_out, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("reload_k_step", k_out, 32'h2004);

    // Asynchronous reset in the middle of an N load.
    rst_n_in = 1'b0;
    #1;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    load_chan(1'b0, 32'hB000, 0, 30);
    load_valid_in = 1'b1;
    load_sel_in   = 1'b0;
    load_block_in = 32'hB01E;
    #2 rst_n_in = 1'b0;
    #1;
    chk("midrst_n_loaded", N_loaded_out, 1'b0);
    chk("midrst_k_loaded", k_loaded_out, 1'b0);
    chk("midrst_ready", ready_out, 1'b0);
    chk("midrst_k_out", k_out, 32'h0);
    idle_in();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    load_chan(1'b0, 32'hC000, 0, 63);
    chk("midrst_not_early", N_loaded_out, 1'b0);
    load_chan(1'b0, 32'hC000, 63, 1);
    chk("midrst_n_loaded2", N_loaded_out, 1'b1);
    chk("midrst_n_out", N_out, 32'hC000);
    chk("midrst_k_empty", k_loaded_out, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/montgomery_constant_streamer.md
Name: montgomery_constant_streamer

Overview:
- Responder for the N/k constant-block handshake used by the Montgomery reducer and squarer streams.
- Stores the modulus N and the Montgomery constant k, each BITS_IN_NUM wide, loaded block-wise from the host/UART side.
- Presents the current REGISTER_SIZE block of each constant continuously. Advances per channel on each consumed pulse and wraps after the last block, so the constants replay indefinitely across squaring iterations.

Parameters:
- REGISTER_SIZE, 32, block width in bits.
- BITS_IN_NUM, 2048, width of each stored constant N and k.
- NUM_BLOCKS, BITS_IN_NUM/REGISTER_SIZE (64), blocks per constant; derived, not overridden.

Ports:
- clk_in  in  1  clock.
- rst_n_in  in  1  asynchronous active-low reset.
- load_valid_in  in  1  load_block_in is valid this cycle.
- load_sel_in  in  1  0 = block belongs to N, 1 = block belongs to k.
- load_block_in  in  REGISTER_SIZE  constant block, least-significant block first.
- rewind_in  in  1  return both read pointers to block 0.
- consumed_N_in  in  1  consumer took the current N block (1-cycle pulse).
- consumed_k_in  in  1  consumer took the current k block (1-cycle pulse).
- N_out  out  REGISTER_SIZE  current N block.
- k_out  out  REGISTER_SIZE  current k block.
- N_loaded_out  out  1  all NUM_BLOCKS blocks of N are written.
- k_loaded_out  out  1  all NUM_BLOCKS blocks of k are written.
- ready_out  out  1  N_loaded_out & k_loaded_out.
- underrun_err_out  out  1  sticky: a consume arrived for a channel that was not loaded.

Behaviour:
- Reset (asynchronous, rst_n_in low):
  - Read pointers, write pointers, loaded flags and underrun_err_out all go to 0.
  - Storage contents are not cleared.
  - N_out and k_out read as 0 while the channel is not loaded.
- Per-channel state machine (N and k are independent), states EMPTY, LOADING, LOADED:
  - EMPTY -> LOADING on the first load_valid_in for that channel; the block is written at index 0 and the write pointer becomes 1.
  - LOADING: each valid block is written at the write pointer, which then increments.
  - LOADING -> LOADED on the write of index NUM_BLOCKS-1. The loaded flag rises the next cycle and the read pointer is set to 0.
  - LOADED -> LOADING on any new load_valid_in for that channel. That block is written at index 0, the loaded flag drops the next cycle and the read pointer is set to 0. This is how a channel is reloaded.
- Read side:
  - Output is combinational from storage at the registered read pointer, so a new block is visible the cycle after a consume pulse. Latency is 0 cycles from pointer to data.
  - A consume pulse in LOADED increments the read pointer. At NUM_BLOCKS-1 the pointer wraps to 0.
  - A consume pulse when the channel is not LOADED sets underrun_err_out. The pointer does not move.
  - underrun_err_out clears only on reset.
- Simultaneous events:
  - load_valid_in and a consume on the same channel in the same cycle: the load wins and the read pointer goes to 0. If the channel was LOADED, underrun_err_out is not set.
  - rewind_in together with a consume: rewind wins and the pointer goes to 0.
  - rewind_in in a non-LOADED state has no effect on the write pointer.
  - Consumes on N and k in the same cycle are independent.
- Width rules:
  - Pointers are $clog2(NUM_BLOCKS) bits.
  - Wrap is an explicit compare against NUM_BLOCKS-1, not natural overflow, so a non-power-of-two NUM_BLOCKS still works.
- Storage: two NUM_BLOCKS x REGISTER_SIZE arrays with one synchronous write port and one asynchronous-index read each. They are BRAM-mappable only if the read is made registered, which is not required.

Decomposition:
- Shared package montgomery_pkg:
  - constants REGISTER_SIZE, BITS_IN_NUM and NUM_BLOCKS;
  - enum const_chan_state_t {EMPTY, LOADING, LOADED};
  - channel select constants SEL_N = 0 and SEL_K = 1.
- One sub-module: const_block_channel. It holds one constant's array, write/read pointers, state machine and underrun detect. The top instantiates two of them, ANDs the loaded flags and ORs the underrun flags.

Test Plan:
- Load N with blocks 0x1000+i and k with 0x2000+i for i = 0..63. Expected: N_loaded_out/k_loaded_out rise 1 cycle after the 64th block, ready_out = 1, N_out = 0x1000, k_out = 0x2000.
- Loaded, pulse consumed_N_in 64 times. Expected: N_out steps 0x1001..0x103F and then wraps to 0x1000, while k_out stays 0x2000.
- Pulse consumed_k_in before any load. Expected: underrun_err_out = 1 the next cycle and stays 1, k_out = 0.
- Reload N mid-stream with read pointer at 10, using 0xA000+i. Expected: N_loaded_out drops, and once reloaded N_out = 0xA000. The k pointer is unaffected.
- rewind_in and consumed_N_in in the same cycle with pointer at 5. Expected: N_out = block 0 next cycle.
- Assert rst_n_in low mid-load at block 30. Expected: all flags are 0 immediately, without waiting for a clock edge, and the next load begins at index 0.
